country_car_sensor: RTL and testbench

//   Vehicle-detection front end for the highway/country traffic controller; drives its X input.

---
 rtl/country_car_sensor.sv | 252 +++++++++++++++++++++++++
 tb/tb_country_car_sensor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/country_car_sensor.sv
// ---------------------------------------------------------------------------
// country_car_sensor
//   Vehicle-detection front end for the highway/country traffic controller.
//   It conditions the raw country-road entry and exit loop detectors, keeps
//   a count of queued country cars, and raises X toward the controller while
//   cars wait or are being served. The controller's country light code is
//   read back so departures can be checked against the light and the request
//   can be released after the queue drains on green.
//
// Ports
//   clk         in   1      clock, all state on posedge
//   clear       in   1      synchronous reset, active-high
//   arrive_raw  in   1      entry loop detector (asynchronous, may bounce)
//   depart_raw  in   1      stop-line exit detector (asynchronous, may bounce)
//   cntry       in   2      country light: RED=0, YELLOW=1, GREEN=2, 3 = RED
//   X           out  1      car-waiting request to the controller
//   car_count   out  CNT_W  cars currently queued
//   overflow    out  1      sticky: an arrival was lost at saturation
//   violation   out  1      one-cycle pulse: departure seen on red
// ---------------------------------------------------------------------------
module country_car_sensor #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned MAX_CARS = 15,
    parameter int unsigned HOLD     = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             arrive_raw,
    input  logic             depart_raw,
    input  logic [1:0]       cntry,
    output logic             X,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow,
    output logic             violation
);

    localparam int unsigned DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
    localparam int unsigned N_DET  = 2;

    localparam logic [1:0] CNTRY_RED     = 2'd0;
    localparam logic [1:0] CNTRY_GREEN   = 2'd2;
    localparam logic [1:0] CNTRY_ILLEGAL = 2'd3;

    // Detector index 0 is the entry loop, index 1 the stop-line exit loop.
    localparam int unsigned DET_ARR = 0;
    localparam int unsigned DET_DEP = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_SERVE = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    // ---------------------------------------------------------------------
    // Input path: synchroniser flops, filtered levels, stability counters
    // ---------------------------------------------------------------------
    logic [N_DET-1:0]            raw_c;
    logic [N_DET-1:0]            sync1_q;
    logic [N_DET-1:0]            sync2_q;
    logic [N_DET-1:0]            filt_q;
    logic [N_DET-1:0]            filt_d;
    logic [N_DET-1:0]            evt_q;
    logic [N_DET-1:0]            evt_d;
    logic [N_DET-1:0][DB_W-1:0]  stab_q;
    logic [N_DET-1:0][DB_W-1:0]  stab_d;

    assign raw_c = {depart_raw, arrive_raw};

    // Debounce: the filtered level follows the synchronised level only after
    // DEBOUNCE consecutive disagreeing edges; any agreeing edge restarts it.
    always_comb begin
        filt_d = filt_q;
        evt_d  = '0;
        stab_d = '0;
        for (int i = 0; i < int'(N_DET); i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (stab_q[i] == DB_W'(DEBOUNCE - 1)) begin
                    filt_d[i] = ~filt_q[i];
                    // Only the rising transition of the filtered level is an event.
                    evt_d[i]  = ~filt_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Input path registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            evt_q   <= '0;
            stab_q  <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            evt_q   <= evt_d;
            stab_q  <= stab_d;
        end
    end

    // ---------------------------------------------------------------------
    // Car counter, overflow and red-light violation
    // ---------------------------------------------------------------------
    logic             arr_evt_c;
    logic             dep_evt_c;
    logic             is_red_c;
    logic             is_green_c;
    logic             at_max_c;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             viol_q;
    logic             viol_d;

    assign arr_evt_c  = evt_q[DET_ARR];
    assign dep_evt_c  = evt_q[DET_DEP];
    // The illegal code is treated as red so a broken controller fails safe.
    assign is_red_c   = (cntry == CNTRY_RED) || (cntry == CNTRY_ILLEGAL);
    assign is_green_c = (cntry == CNTRY_GREEN);
    assign at_max_c   = (count_q == CNT_W'(MAX_CARS));

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        viol_d  = 1'b0;
        unique case ({arr_evt_c, dep_evt_c})
            2'b10: begin
                if (at_max_c) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            2'b01: begin
                // A car leaving on red is flagged but not removed from the queue.
                if (is_red_c) begin
                    viol_d = 1'b1;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            2'b11: begin
                // On non-red one car in and one car out cancel; on red the
                // departure is not honoured, so only the arrival counts.
                if (is_red_c) begin
                    viol_d = 1'b1;
                    if (at_max_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            viol_q  <= viol_d;
        end
    end

    // ---------------------------------------------------------------------
    // Request FSM and post-drain gap timer
    // ---------------------------------------------------------------------
    state_e            state_q;
    state_e            state_d;
    logic [HOLD_W-1:0] timer_q;
    logic [HOLD_W-1:0] timer_d;
    logic              queue_empty_c;

    assign queue_empty_c = (count_q == '0);

    // Next-state logic; priority is top-down within each state.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (!queue_empty_c) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (queue_empty_c) begin
                    state_d = S_IDLE;
                end else if (is_green_c) begin
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                if (queue_empty_c) begin
                    state_d = S_HOLD;
                    timer_d = HOLD_W'(HOLD);
                end else if (!is_green_c) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (!queue_empty_c) begin
                    state_d = S_SERVE;
                end else if (!is_green_c) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - HOLD_W'(1);
                    if (timer_q == HOLD_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and timer registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Outputs come straight from registers.
    assign X         = (state_q != S_IDLE);
    assign car_count = count_q;
    assign overflow  = ovf_q;
    assign violation = viol_q;

endmodule

// File: tb/tb_country_car_sensor.sv
// ---------------------------------------------------------------------------
// tb_country_car_sensor
//   Directed bench for country_car_sensor (DEBOUNCE=3, CNT_W=4, MAX_CARS=15,
//   HOLD=2). Stimulus pushes hand-computed expectations tagged with the edge
//   after which they must hold; a monitor pops and compares on each negedge.
//   A detector input raised after edge t changes car_count after edge t+6.
// ---------------------------------------------------------------------------
module tb_country_car_sensor;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic       clk;
    logic       clear;
    logic       arrive_raw;
    logic       depart_raw;
    logic [1:0] cntry;
    logic       X;
    logic [3:0] car_count;
    logic       overflow;
    logic       violation;

    country_car_sensor #(
        .DEBOUNCE (3),
        .CNT_W    (4),
        .MAX_CARS (15),
        .HOLD     (2)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .arrive_raw (arrive_raw),
        .depart_raw (depart_raw),
        .cntry      (cntry),
        .X          (X),
        .car_count  (car_count),
        .overflow   (overflow),
        .violation  (violation)
    );

    typedef struct {
        int unsigned at_edge;
        logic [3:0]  cnt;
        logic        x;
        logic        ovf;
        logic        viol;
        logic [1:0]  st;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc   = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int unsigned e, input logic [3:0] c, input logic x,
                             input logic o, input logic v, input logic [1:0] s,
                             input string n);
        exp_t item;
        item.at_edge = e;
        item.cnt     = c;
        item.x       = x;
        item.ovf     = o;
        item.viol    = v;
        item.st      = s;
        item.name    = n;
        sb_q.push_back(item);
    endtask

    // Advance until edge c has passed; inputs set afterwards are first sampled at edge c+1.
    task automatic goto(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due at the edge just passed.
    always @(negedge clk) begin
        logic [1:0] st_got;
        exp_t       e;
        st_got = dut.state_q;
        while (sb_q.size() != 0 && sb_q[0].at_edge <= cyc) begin
            e = sb_q.pop_front();
            tests++;
            if (e.at_edge != cyc) begin
                fails++;
                $display("FAIL %s: expectation for edge %0d not checked (now edge %0d)",
                         e.name, e.at_edge, cyc);
            end else if (car_count !== e.cnt || X !== e.x || overflow !== e.ovf ||
                         violation !== e.viol || st_got !== e.st) begin
                fails++;
                $display("FAIL %s @edge %0d: got cnt=%0d X=%b ovf=%b viol=%b st=%0d, required cnt=%0d X=%b ovf=%b viol=%b st=%0d",
                         e.name, cyc, car_count, X, overflow, violation, st_got,
                         e.cnt, e.x, e.ovf, e.viol, e.st);
            end
        end
    end

    initial begin
        clear      = 1'b1;
        arrive_raw = 1'b0;
        depart_raw = 1'b1;
        cntry      = 2'd2;

        // 1: reset held 3 edges while raw inputs toggle
        expect_at(1, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, "reset_e1");
        expect_at(2, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, "reset_e2");
        expect_at(3, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, "reset_e3");
        expect_at(4, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, "post_reset");
        for (int i = 1; i <= 3; i++) begin
            goto(i);
            arrive_raw = ~arrive_raw;
            depart_raw = ~depart_raw;
            cntry      = 2'(i);
        end
        clear      = 1'b0;
        arrive_raw = 1'b0;
        depart_raw = 1'b0;
        cntry      = 2'd0;

        // 2: arrival first sampled at edge 10
        expect_at(14, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, "lat_before");
        expect_at(15, 4'd1, 1'b0, 1'b0, 1'b0, ST_IDLE, "lat_count");
        expect_at(16, 4'd1, 1'b1, 1'b0, 1'b0, ST_REQ,  "lat_x");
        goto(9);  arrive_raw = 1'b1;
        goto(14); arrive_raw = 1'b0;

        // 3: bounce 2 high, 1 low, 2 high is rejected
        expect_at(30, 4'd1, 1'b1, 1'b0, 1'b0, ST_REQ, "bounce_a");
        expect_at(35, 4'd1, 1'b1, 1'b0, 1'b0, ST_REQ, "bounce_b");
        goto(20); arrive_raw = 1'b1;
        goto(22); arrive_raw = 1'b0;
        goto(23); arrive_raw = 1'b1;
        goto(25); arrive_raw = 1'b0;

        // 4: second arrival, green, two departures, gap then release
        expect_at(41, 4'd2, 1'b1, 1'b0, 1'b0, ST_REQ,   "serve_cnt2");
        expect_at(46, 4'd2, 1'b1, 1'b0, 1'b0, ST_SERVE, "serve_enter");
        expect_at(52, 4'd1, 1'b1, 1'b0, 1'b0, ST_SERVE, "serve_dep1");
        expect_at(62, 4'd0, 1'b1, 1'b0, 1'b0, ST_SERVE, "serve_dep2");
        expect_at(63, 4'd0, 1'b1, 1'b0, 1'b0, ST_HOLD,  "hold_1");
        expect_at(64, 4'd0, 1'b1, 1'b0, 1'b0, ST_HOLD,  "hold_2");
        expect_at(65, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE,  "hold_release");
        goto(35); arrive_raw = 1'b1;
        goto(40); arrive_raw = 1'b0;
        goto(45); cntry      = 2'd2;
        goto(46); depart_raw = 1'b1;
        goto(51); depart_raw = 1'b0;
        goto(56); depart_raw = 1'b1;
        goto(61); depart_raw = 1'b0;

        // 4b: arrival landing while in HOLD sends the FSM back to SERVE
        expect_at(72, 4'd1, 1'b0, 1'b0, 1'b0, ST_IDLE,  "rearm_cnt");
        expect_at(73, 4'd1, 1'b1, 1'b0, 1'b0, ST_REQ,   "rearm_req");
        expect_at(74, 4'd1, 1'b1, 1'b0, 1'b0, ST_SERVE, "rearm_serve");
        expect_at(80, 4'd0, 1'b1, 1'b0, 1'b0, ST_SERVE, "drain_again");
        expect_at(81, 4'd1, 1'b1, 1'b0, 1'b0, ST_HOLD,  "hold_arrival");
        expect_at(82, 4'd1, 1'b1, 1'b0, 1'b0, ST_SERVE, "hold_to_serve");
        expect_at(85, 4'd1, 1'b1, 1'b0, 1'b0, ST_SERVE, "serve_steady");
        goto(66); arrive_raw = 1'b1;
        goto(71); arrive_raw = 1'b0;
        goto(74); depart_raw = 1'b1;
        goto(75); arrive_raw = 1'b1;
        goto(79); depart_raw = 1'b0;
        goto(80); arrive_raw = 1'b0;

        // 5: fill to 15, simultaneous in/out at 15 on green, then overflow
        expect_at(211, 4'd14, 1'b1, 1'b0, 1'b0, ST_SERVE, "fill_14");
        expect_at(221, 4'd15, 1'b1, 1'b0, 1'b0, ST_SERVE, "fill_15");
        expect_at(231, 4'd15, 1'b1, 1'b0, 1'b0, ST_SERVE, "both_at_max");
        expect_at(241, 4'd15, 1'b1, 1'b1, 1'b0, ST_SERVE, "overflow_set");
        expect_at(245, 4'd15, 1'b1, 1'b1, 1'b0, ST_SERVE, "overflow_sticky");
        for (int i = 0; i < 14; i++) begin
            goto(85 + 10 * i); arrive_raw = 1'b1;
            goto(90 + 10 * i); arrive_raw = 1'b0;
        end
        goto(225); arrive_raw = 1'b1; depart_raw = 1'b1;
        goto(230); arrive_raw = 1'b0; depart_raw = 1'b0;
        goto(235); arrive_raw = 1'b1;
        goto(240); arrive_raw = 1'b0;

        // drain to 2 on green
        expect_at(361, 4'd3, 1'b1, 1'b1, 1'b0, ST_SERVE, "drain_3");
        expect_at(371, 4'd2, 1'b1, 1'b1, 1'b0, ST_SERVE, "drain_2");
        for (int j = 0; j < 13; j++) begin
            goto(245 + 10 * j); depart_raw = 1'b1;
            goto(250 + 10 * j); depart_raw = 1'b0;
        end

        // 6: red runner, then clear with the entry loop held high
        expect_at(376, 4'd2, 1'b1, 1'b1, 1'b0, ST_REQ, "red_req");
        expect_at(382, 4'd2, 1'b1, 1'b1, 1'b1, ST_REQ, "viol_pulse");
        expect_at(383, 4'd2, 1'b1, 1'b1, 1'b0, ST_REQ, "viol_end");
        expect_at(387, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, "clear_mid");
        expect_at(388, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, "clear_after");
        expect_at(392, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE, "held_before");
        expect_at(393, 4'd1, 1'b0, 1'b0, 1'b0, ST_IDLE, "held_counted");
        expect_at(394, 4'd1, 1'b1, 1'b0, 1'b0, ST_REQ,  "held_x");
        goto(375); cntry      = 2'd0;
        goto(376); depart_raw = 1'b1;
        goto(381); depart_raw = 1'b0;
        goto(386); clear      = 1'b1; arrive_raw = 1'b1;
        goto(387); clear      = 1'b0;
        goto(392); arrive_raw = 1'b0;

        // illegal light code behaves as red
        expect_at(403, 4'd1, 1'b1, 1'b0, 1'b1, ST_REQ, "illegal_viol");
        expect_at(404, 4'd1, 1'b1, 1'b0, 1'b0, ST_REQ, "illegal_end");
        goto(397); cntry = 2'd3; depart_raw = 1'b1;
        goto(402); depart_raw = 1'b0;

        // drain to 0 on green, then a departure at 0 holds with no flag
        expect_at(408, 4'd1, 1'b1, 1'b0, 1'b0, ST_SERVE, "last_serve");
        expect_at(413, 4'd0, 1'b1, 1'b0, 1'b0, ST_SERVE, "last_drain");
        expect_at(414, 4'd0, 1'b1, 1'b0, 1'b0, ST_HOLD,  "last_hold1");
        expect_at(415, 4'd0, 1'b1, 1'b0, 1'b0, ST_HOLD,  "last_hold2");
        expect_at(416, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE,  "last_idle");
        expect_at(423, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE,  "dep_at_zero");
        expect_at(424, 4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE,  "dep_at_zero_b");
        goto(407); cntry = 2'd2; depart_raw = 1'b1;
        goto(412); depart_raw = 1'b0;
        goto(417); depart_raw = 1'b1;
        goto(422); depart_raw = 1'b0;

        goto(430);
        @(negedge clk);
        #1;
        while (sb_q.size() != 0) begin
            exp_t left;
            left = sb_q.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: expectation for edge %0d never checked", left.name, left.at_edge);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
